// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: sequences push/pop requests from the instruction controller
// onto a single-port, registered-read data memory that holds the operand stack.
// Tracks the stack pointer (count), reports completion and full/empty status,
// and keeps sticky overflow/underflow flags until cleared.

module stack_mem_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int STACK_BASE = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_WR  = 2'd1,
    POP_RD   = 2'd2,
    POP_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(STACK_BASE);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] wr_latch;

  // Slot addresses: count is the next free slot, count-1 is the top of stack.
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] top_addr;

  assign push_addr = BASE_ADDR + ADDR_W'(count);
  assign top_addr  = push_addr - ADDR_W'(1);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // Request sequencing, stack pointer, status pulses and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      pop_data  <= '0;
      wr_latch  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values;
      // the later assignments below let a new error win over clr_err.
      done <= 1'b0;
      err  <= 1'b0;
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (push && pop) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (push) begin
            if (full) begin
              done     <= 1'b1;
              err      <= 1'b1;
              overflow <= 1'b1;
            end else begin
              wr_latch <= push_data;
              state    <= PUSH_WR;
            end
          end else if (pop) begin
            if (empty) begin
              done      <= 1'b1;
              err       <= 1'b1;
              underflow <= 1'b1;
            end else begin
              state <= POP_RD;
            end
          end
        end
        PUSH_WR: begin
          count <= count + CNT_W'(1);
          done  <= 1'b1;
          state <= IDLE;
        end
        POP_RD: begin
          state <= POP_WAIT;
        end
        POP_WAIT: begin
          pop_data <= mem_rdata;
          count    <= count - CNT_W'(1);
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port decode; enables are forced low while rst is high.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    mem_addr  = BASE_ADDR;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      PUSH_WR: begin
        mem_addr  = push_addr;
        mem_wdata = wr_latch;
        mem_we    = !rst;
      end
      POP_RD: begin
        mem_addr = top_addr;
        mem_re   = !rst;
      end
      POP_WAIT: begin
        mem_addr = top_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl: a queue-based stack model plus a
// registered-read memory model, directed scenarios and a randomized sequence.

module tb_stack_mem_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int BASE   = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic [DATA_W-1:0] pop_data;
  logic              busy, done, err, full, empty, overflow, underflow;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata = '0;

  stack_mem_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_BASE(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .pop_data(pop_data), .busy(busy), .done(done), .err(err), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read; counts every access edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we || mem_re) acc_cnt++;
  end

  // Reference model.
  logic [DATA_W-1:0] stk[$];
  logic [DATA_W-1:0] m_pop_data = '0;
  logic              m_ov = 1'b0, m_un = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic do_push(input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] ea;
    ea = ADDR_W'(BASE + stk.size());
    push = 1'b1; pop = 1'b0; push_data = d;
    @(posedge clk); #1;
    push = 1'($urandom); pop = 1'($urandom); push_data = DATA_W'($urandom);
    tests++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== ea ||
        mem_wdata !== d || done !== 1'b0) begin
      fails++;
      $display("FAIL push_wr: busy=%b we=%b re=%b addr=%0d wdata=%h done=%b, want busy=1 we=1 re=0 addr=%0d wdata=%h done=0",
               busy, mem_we, mem_re, mem_addr, mem_wdata, done, ea, d);
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    stk.push_back(d);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || count !== CNT_W'(stk.size()) ||
        mem_we !== 1'b0 || pop_data !== m_pop_data || full !== (stk.size() == DEPTH) ||
        empty !== 1'b0) begin
      fails++;
      $display("FAIL push_done: done=%b err=%b busy=%b count=%0d full=%b empty=%b pop_data=%h, want done=1 err=0 busy=0 count=%0d full=%b empty=0 pop_data=%h",
               done, err, busy, count, full, empty, pop_data, stk.size(), stk.size() == DEPTH, m_pop_data);
    end
  endtask

  task automatic do_pop();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] exp_d;
    ea = ADDR_W'(BASE + stk.size() - 1);
    pop = 1'b1; push = 1'b0;
    @(posedge clk); #1;
    push = 1'($urandom); pop = 1'($urandom);
    tests++;
    if (busy !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || done !== 1'b0) begin
      fails++;
      $display("FAIL pop_rd: busy=%b re=%b we=%b addr=%0d done=%b, want busy=1 re=1 we=0 addr=%0d done=0",
               busy, mem_re, mem_we, mem_addr, done, ea);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL pop_wait: busy=%b re=%b we=%b done=%b, want busy=1 re=0 we=0 done=0",
               busy, mem_re, mem_we, done);
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    exp_d = stk.pop_back();
    m_pop_data = exp_d;
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || pop_data !== exp_d ||
        count !== CNT_W'(stk.size()) || empty !== (stk.size() == 0) || full !== 1'b0) begin
      fails++;
      $display("FAIL pop_done: done=%b err=%b busy=%b pop_data=%h count=%0d empty=%b full=%b, want done=1 err=0 busy=0 pop_data=%h count=%0d empty=%b full=0",
               done, err, busy, pop_data, count, empty, full, exp_d, stk.size(), stk.size() == 0);
    end
  endtask

  // Only called where the request is guaranteed to be rejected by the model.
  task automatic do_reject(input logic p, input logic q, input logic clr);
    int acc0;
    acc0 = acc_cnt;
    push = p; pop = q; clr_err = clr; push_data = DATA_W'($urandom);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    m_ov = (p && !q) ? 1'b1 : (m_ov && !clr);
    m_un = (q && !p) ? 1'b1 : (m_un && !clr);
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || overflow !== m_ov ||
        underflow !== m_un || count !== CNT_W'(stk.size()) || mem_we !== 1'b0 ||
        mem_re !== 1'b0 || acc_cnt != acc0) begin
      fails++;
      $display("FAIL reject(p=%b q=%b clr=%b): done=%b err=%b busy=%b ov=%b un=%b count=%0d we=%b re=%b acc=%0d, want done=1 err=1 busy=0 ov=%b un=%b count=%0d we=0 re=0 acc=%0d",
               p, q, clr, done, err, busy, overflow, underflow, count, mem_we, mem_re, acc_cnt,
               m_ov, m_un, stk.size(), acc0);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || err !== 1'b0 || acc_cnt != acc0) begin
      fails++;
      $display("FAIL reject_after: done=%b err=%b acc=%0d, want done=0 err=0 acc=%0d",
               done, err, acc_cnt, acc0);
    end
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    m_ov = 1'b0; m_un = 1'b0;
    tests++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL clr_err: ov=%b un=%b done=%b, want 0 0 0", overflow, underflow, done);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pop_data = '0; m_ov = 1'b0; m_un = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || pop_data !== '0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: count=%0d empty=%b full=%b busy=%b done=%b err=%b pop_data=%h we=%b re=%b ov=%b un=%b",
                 i, count, empty, full, busy, done, err, pop_data, mem_we, mem_re, overflow, underflow);
      end
    end
    rst = 1'b0;
    model_reset();
    // Reset arriving while a write is pending must suppress mem_we at once.
    push = 1'b1; push_data = 8'h5A;
    @(posedge clk); #1;
    push = 1'b0;
    rst = 1'b1; #1;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_gate_we: mem_we=%b, want 0", mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL reset_abort_push: done=%b busy=%b count=%0d, want 0 0 0", done, busy, count);
    end
  endtask

  task automatic test_push_pop_basic();
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    do_pop(); do_pop(); do_pop();
  endtask

  task automatic test_overflow();
    while (stk.size() < DEPTH) do_push(DATA_W'($urandom));
    do_reject(1'b1, 1'b0, 1'b0);
    do_clr();
  endtask

  task automatic test_underflow();
    while (stk.size() > 0) do_pop();
    do_reject(1'b0, 1'b1, 1'b0);
    do_reject(1'b0, 1'b1, 1'b1);
    do_clr();
  endtask

  task automatic test_simultaneous();
    do_push(8'hC3); do_push(8'h3C);
    do_reject(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_pop();
    while (stk.size() < 3) do_push(DATA_W'($urandom));
    while (stk.size() > 3) do_pop();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || count !== '0 || busy !== 1'b0 || pop_data !== '0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pop: done=%b count=%0d busy=%b pop_data=%h empty=%b, want 0 0 0 00 1",
               done, count, busy, pop_data, empty);
    end
    rst = 1'b0;
    model_reset();
    do_push(8'h77);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        if (stk.size() < DEPTH) do_push(DATA_W'($urandom));
        else do_reject(1'b1, 1'b0, 1'($urandom));
      end else if (r < 8) begin
        if (stk.size() > 0) do_pop();
        else do_reject(1'b0, 1'b1, 1'($urandom));
      end else if (r == 8) begin
        do_reject(1'b1, 1'b1, 1'($urandom));
      end else begin
        do_clr();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_pop_basic();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
Sequences the memory-resident operand stack of the stack processor. The instruction controller issues single-cycle push/pop requests; this block walks the single-port data memory through the write or read cycles, maintains the stack pointer, and reports completion, full/empty status and overflow/underflow errors. It sits between the instruction controller and the datapath memory port.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 8, memory/stack word width
STACK_BASE, 16, address of stack slot 0; STACK_BASE+DEPTH must be <= 2**ADDR_W
DEPTH, 16, maximum number of stacked words
CNT_W, $clog2(DEPTH+1), width of count

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
push  in  1  push request, sampled only in IDLE
pop  in  1  pop request, sampled only in IDLE
push_data  in  DATA_W  word to push, sampled with push
pop_data  out  DATA_W  last popped word, held until next successful pop
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse: request finished (success or reject)
err  out  1  one-cycle pulse with done when the request was rejected
count  out  CNT_W  current stack occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
clr_err  in  1  clears overflow/underflow
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable; memory returns mem_rdata one cycle later (registered read)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst high at an edge): state IDLE, count=0, pop_data=0, data latch=0, done=err=overflow=underflow=0. mem_we and mem_re are gated combinationally by !rst, so no memory access occurs in any cycle where rst is high. Reset mid-operation aborts it with no done pulse.
- States: IDLE, PUSH_WR, POP_RD, POP_WAIT.
- IDLE, push=1, pop=0, !full: latch push_data, go to PUSH_WR.
- PUSH_WR (1 cycle): mem_addr=STACK_BASE+count, mem_wdata=latched data, mem_we=1. At the next edge: count+1, done=1 (registered, visible the following cycle), go to IDLE.
- IDLE, pop=1, push=0, !empty: go to POP_RD.
- POP_RD: mem_addr=STACK_BASE+count-1, mem_re=1. Next state: POP_WAIT.
- POP_WAIT: mem_rdata is valid. At the next edge: pop_data<=mem_rdata, count-1, done=1, go to IDLE.
- Latency from the request-sampling edge N: push done high in the cycle after edge N+1; pop done high in the cycle after edge N+2, with pop_data valid in that same cycle.
- Reject cases (state stays IDLE, no memory access, count unchanged; done=err=1 in the cycle after the sampling edge):
  - push while full: overflow set.
  - pop while empty: underflow set.
  - push and pop together: neither sticky flag changes.
- push/pop while busy: ignored, with no effect and no done. The requester must wait for done before issuing the next request.
- clr_err clears both sticky flags at the edge. If a new error is detected at the same edge, the set wins.
- In IDLE: mem_addr=STACK_BASE, mem_wdata=0, mem_we=mem_re=0.
- full/empty are combinational from count. Address arithmetic is ADDR_W bits wide and never wraps under the parameter constraint.
- A new request may be sampled at the same edge that done is registered only if the block is already in IDLE, i.e. back-to-back requests are accepted in the done cycle.

Test Plan:
- Reset: hold rst 2 cycles -> count=0, empty=1, full=0, busy=0, done=0, pop_data=0, mem_we=0 during reset.
- Push 0x11, 0x22, 0x33 then pop three times -> mem writes at addresses 16, 17, 18; each push done 2 cycles after request; pops return 0x33, 0x22, 0x11 (reads at 18, 17, 16), each done 3 cycles after request; count ends at 0, empty=1.
- Push 16 words (full=1), then push 0xAA -> done=err=1 one cycle later, overflow=1, no mem_we, count=16. Assert clr_err -> overflow=0.
- Pop while empty -> done=err=1, underflow=1, mem_re never asserted. Assert clr_err together with a second empty pop -> underflow stays 1.
- push=pop=1 in IDLE with count=2 -> done=err=1, count=2, overflow=underflow=0, no memory access.
- Reset asserted during POP_WAIT with count=3 -> no done pulse, count=0, state IDLE, pop_data=0; a subsequent push writes address 16.
